// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl_pkg
//  Description : Shared fetch-side definitions for the I-cache refill engine:
//                refill FSM encoding, PC width and word-align helper.
//  Revision    : 1.0  initial release
// ============================================================================
package icache_refill_ctrl_pkg;

  localparam int PC_WIDTH = 32;

  // Clears the byte offset of a PC to form a word-aligned bus address.
  localparam logic [PC_WIDTH-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_FILL = 3'd3,
    ST_ERR  = 3'd4
  } refill_state_t;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] pc);
    return pc & WORD_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_timer.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_timer
//  Description : Response timeout counter and retry counter for the refill
//                engine. Flags expiry on the last waiting cycle and flags
//                exhaustion once all re-issues have been used.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_refill_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic timeout_clear,
  input  logic timeout_tick,
  input  logic retry_clear,
  input  logic retry_inc,
  output logic timeout_expire,
  output logic retry_exhausted
);

  localparam int TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [TO_W-1:0]    r_timeout_cnt;
  logic [RETRY_W-1:0] r_retry_cnt;

  // Timeout counter: restarted on grant, advances each waiting cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_timeout_cnt <= '0;
    end else if (timeout_clear) begin
      r_timeout_cnt <= '0;
    end else if (timeout_tick) begin
      r_timeout_cnt <= r_timeout_cnt + TO_W'(1);
    end
  end

  // Retry counter: restarted per miss, bumped on each re-issue.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_retry_cnt <= '0;
    end else if (retry_clear) begin
      r_retry_cnt <= '0;
    end else if (retry_inc) begin
      r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
    end
  end

  assign timeout_expire  = (r_timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign retry_exhausted = (r_retry_cnt >= RETRY_W'(MAX_RETRY));

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : Miss handler and refill engine for the direct-mapped
//                instruction cache. Stalls fetch on a miss, reads the word
//                from memory with timeout/retry, and writes it back to the
//                cache with a single-cycle fill.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                fetch_valid,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                cache_hit,
  input  logic                flush,
  output logic                stall_fetch,
  output logic                fetch_error,
  output logic                fill_write_request,
  output logic [PC_WIDTH-1:0] fill_write_address,
  output logic [31:0]         fill_write_data,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                mem_req_id,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic                mem_rsp_id,
  input  logic [31:0]         mem_rdata
);

  refill_state_t       r_state;
  refill_state_t       w_state_nxt;
  logic [PC_WIDTH-1:0] r_miss_pc;
  logic [31:0]         r_rdata;
  logic                r_cur_id;

  logic w_latch_miss;
  logic w_capture;
  logic w_toggle_id;
  logic w_timeout_clear;
  logic w_timeout_tick;
  logic w_retry_inc;
  logic w_timeout_expire;
  logic w_retry_exhausted;

  icache_refill_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) u_timer (
    .CLK             (CLK),
    .RESET           (RESET),
    .timeout_clear   (w_timeout_clear),
    .timeout_tick    (w_timeout_tick),
    .retry_clear     (w_latch_miss),
    .retry_inc       (w_retry_inc),
    .timeout_expire  (w_timeout_expire),
    .retry_exhausted (w_retry_exhausted)
  );

  // State, miss PC, captured word and transaction tag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_miss_pc <= '0;
      r_rdata   <= '0;
      r_cur_id  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_miss) r_miss_pc <= fetch_pc;
      if (w_capture)    r_rdata   <= mem_rdata;
      if (w_toggle_id)  r_cur_id  <= ~r_cur_id;
    end
  end

  // Next-state and output decode; flush overrides whatever the state chose.
  always_comb begin
    w_state_nxt        = r_state;
    w_latch_miss       = 1'b0;
    w_capture          = 1'b0;
    w_toggle_id        = 1'b0;
    w_timeout_clear    = 1'b0;
    w_timeout_tick     = 1'b0;
    w_retry_inc        = 1'b0;
    fetch_error        = 1'b0;
    fill_write_request = 1'b0;
    fill_write_address = '0;
    fill_write_data    = '0;
    mem_req            = 1'b0;
    mem_addr           = '0;
    mem_req_id         = 1'b0;
    // Combinational term lets the miss stall fetch in its detection cycle.
    stall_fetch        = (r_state != ST_IDLE) | (fetch_valid & ~cache_hit);

    case (r_state)
      ST_IDLE: begin
        if (fetch_valid && !cache_hit) begin
          w_latch_miss = 1'b1;
          w_toggle_id  = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req    = 1'b1;
        mem_addr   = word_align(r_miss_pc);
        mem_req_id = r_cur_id;
        if (mem_gnt) begin
          w_timeout_clear = 1'b1;
          w_state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_timeout_tick = 1'b1;
        // A matching response wins over a coincident timeout expiry.
        if (mem_rvalid && (mem_rsp_id == r_cur_id)) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_FILL;
        end else if (w_timeout_expire) begin
          if (!w_retry_exhausted) begin
            w_retry_inc = 1'b1;
            w_toggle_id = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_FILL: begin
        fill_write_request = 1'b1;
        fill_write_address = r_miss_pc;
        fill_write_data    = r_rdata;
        w_state_nxt        = ST_IDLE;
      end
      ST_ERR: begin
        fetch_error = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Redirect abandons the miss; the tag flip orphans any in-flight reply.
    if (flush) begin
      w_state_nxt        = ST_IDLE;
      w_latch_miss       = 1'b0;
      w_capture          = 1'b0;
      w_retry_inc        = 1'b0;
      w_toggle_id        = 1'b1;
      fill_write_request = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_ctrl
//  Description : Scoreboard bench for icache_refill_ctrl: directed misses,
//                retries, exhaustion, flush and async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_refill_ctrl;

  localparam int TO = 4;
  localparam int MR = 2;

  logic        CLK;
  logic        RESET;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        cache_hit;
  logic        flush;
  logic        stall_fetch;
  logic        fetch_error;
  logic        fill_write_request;
  logic [31:0] fill_write_address;
  logic [31:0] fill_write_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_req_id;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic        mem_rsp_id;
  logic [31:0] mem_rdata;

  icache_refill_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MR)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .cache_hit          (cache_hit),
    .flush              (flush),
    .stall_fetch        (stall_fetch),
    .fetch_error        (fetch_error),
    .fill_write_request (fill_write_request),
    .fill_write_address (fill_write_address),
    .fill_write_data    (fill_write_data),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_req_id         (mem_req_id),
    .mem_gnt            (mem_gnt),
    .mem_rvalid         (mem_rvalid),
    .mem_rsp_id         (mem_rsp_id),
    .mem_rdata          (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard queues: {addr, id} per granted request, {addr, data} per fill.
  logic [32:0] exp_req[$];
  logic [63:0] exp_fill[$];
  logic [32:0] mon_req;
  logic [63:0] mon_fill;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_gnt = 0;
  int   st_cnt = 0;
  logic m_id;
  logic old_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each grant handshake and each fill pulse to the queues.
  always @(negedge CLK) begin
    if (RESET) begin
      if (mem_req && mem_gnt) begin
        n_gnt++;
        if (exp_req.size() == 0) begin
          chk("unexpected_request", {31'd0, mem_addr, mem_req_id}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_req = exp_req.pop_front();
          chk("mem_request", {31'd0, mem_addr, mem_req_id}, {31'd0, mon_req});
        end
      end
      if (fill_write_request) begin
        if (exp_fill.size() == 0) begin
          chk("unexpected_fill", {fill_write_address, fill_write_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_fill = exp_fill.pop_front();
          chk("fill_write", {fill_write_address, fill_write_data}, mon_fill);
        end
      end
    end
  end

  task automatic half();
    @(negedge CLK);
    if (stall_fetch) st_cnt++;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic cycle();
    half();
    adv();
  endtask

  // Minimum-latency miss: same-cycle grant, next-cycle response.
  task automatic quick_miss(input logic [31:0] pc, input logic [31:0] data, input string name);
    st_cnt      = 0;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    cache_hit   = 1'b0;
    m_id        = ~m_id;
    exp_req.push_back({pc & 32'hFFFF_FFFC, m_id});
    exp_fill.push_back({pc, data});
    cycle();
    mem_gnt = 1'b1;
    cycle();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rsp_id = m_id;
    mem_rdata  = data;
    cycle();
    mem_rvalid = 1'b0;
    cycle();
    cache_hit = 1'b1;
    cycle();
    chk(name, 64'(st_cnt), 64'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; cache_hit = 1'b0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rsp_id = 1'b0; mem_rdata = '0; m_id = 1'b0;
    old_id = 1'b0;
    #3;
    chk("reset_ctrl", {59'd0, stall_fetch, fetch_error, fill_write_request, mem_req, mem_req_id}, 64'd0);
    chk("reset_addr", {mem_addr, fill_write_address}, 64'd0);
    chk("reset_data", {32'd0, fill_write_data}, 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    adv();

    // Hit path
    fetch_valid = 1'b1; cache_hit = 1'b1; fetch_pc = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      half();
      chk("hit_path", {61'd0, stall_fetch, mem_req, fill_write_request}, 64'd0);
      adv();
    end

    // Basic miss
    quick_miss(32'h0000_1040, 32'hDEAD_BEEF, "basic_miss_stall");

    // Timeout and retry, late old-id response ignored
    st_cnt = 0; fetch_pc = 32'h0000_2006; cache_hit = 1'b0;
    m_id = ~m_id; old_id = m_id;
    exp_req.push_back({32'h0000_2004, m_id});
    exp_fill.push_back({32'h0000_2006, 32'h1234_5678});
    cycle();
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0;
    repeat (TO) cycle();
    m_id = ~m_id;
    exp_req.push_back({32'h0000_2004, m_id});
    mem_gnt = 1'b1;
    half();
    chk("retry_reissue", {62'd0, mem_req, mem_req_id}, {62'd0, 1'b1, m_id});
    adv();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rsp_id = old_id; mem_rdata = 32'hBAD0_BAD0;
    cycle();
    mem_rsp_id = m_id; mem_rdata = 32'h1234_5678;
    cycle();
    mem_rvalid = 1'b0;
    cycle();
    cache_hit = 1'b1;
    cycle();
    chk("retry_stall", 64'(st_cnt), 64'd10);

    // Exhaustion: three grants, never a response
    n_gnt = 0; fetch_pc = 32'h0000_3000; cache_hit = 1'b0;
    m_id = ~m_id;
    exp_req.push_back({32'h0000_3000, m_id});
    cycle();
    for (int a = 0; a <= MR; a++) begin
      mem_gnt = 1'b1;
      cycle();
      mem_gnt = 1'b0;
      repeat (TO) cycle();
      if (a < MR) begin
        m_id = ~m_id;
        exp_req.push_back({32'h0000_3000, m_id});
      end
    end
    fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("err_hold", {61'd0, fetch_error, stall_fetch, mem_req}, 64'b110);
      adv();
    end
    chk("grant_count", 64'(n_gnt), 64'(MR + 1));
    flush = 1'b1; m_id = ~m_id;
    cycle();
    flush = 1'b0;
    half();
    chk("err_flush_clear", {62'd0, fetch_error, stall_fetch}, 64'd0);
    adv();

    // Flush in WAIT, then the old-id response arrives
    fetch_valid = 1'b1; fetch_pc = 32'h0000_4000; cache_hit = 1'b0;
    m_id = ~m_id; old_id = m_id;
    exp_req.push_back({32'h0000_4000, m_id});
    cycle();
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0; flush = 1'b1; fetch_valid = 1'b0; m_id = ~m_id;
    cycle();
    flush = 1'b0; mem_rvalid = 1'b1; mem_rsp_id = old_id; mem_rdata = 32'hBADB_AD00;
    half();
    chk("flush_wait_idle", {61'd0, stall_fetch, fill_write_request, mem_req}, 64'd0);
    adv();
    mem_rvalid = 1'b0;
    cycle();
    quick_miss(32'h0000_5008, 32'hCAFE_F00D, "after_flush_stall");

    // Async reset while waiting for a response
    fetch_valid = 1'b1; fetch_pc = 32'h0000_6000; cache_hit = 1'b0;
    m_id = ~m_id; old_id = m_id;
    exp_req.push_back({32'h0000_6000, m_id});
    cycle();
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0; fetch_valid = 1'b0;
    #2;
    RESET = 1'b0; m_id = 1'b0;
    #1;
    chk("async_rst_ctrl", {59'd0, stall_fetch, fetch_error, fill_write_request, mem_req, mem_req_id}, 64'd0);
    chk("async_rst_addr", {mem_addr, fill_write_address}, 64'd0);
    mem_rvalid = 1'b1; mem_rsp_id = old_id; mem_rdata = 32'hBADC_0DE0;
    adv();
    adv();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("post_reset_quiet", {61'd0, stall_fetch, fill_write_request, mem_req}, 64'd0);
      adv();
    end
    mem_rvalid = 1'b0;
    quick_miss(32'h0000_7000, 32'h0A0B_0C0D, "post_reset_miss_stall");

    repeat (2) cycle();
    chk("req_queue_drained", 64'(exp_req.size()), 64'd0);
    chk("fill_queue_drained", 64'(exp_fill.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling and refill engine for the fetch stage's direct-mapped instruction cache. It watches the cache's read-hit result for the current fetch PC, stalls fetch on a miss, and fetches the missing instruction word from the memory side. It then drives the cache's write port (write request, write address, write data) with a single-cycle fill. It sits between fetch, the instruction cache and the memory/bus interface, and is the only writer of the instruction cache.

## Interface
- TIMEOUT_CYCLES, 64: cycles spent waiting for a memory response before the request is re-issued (≥2).
- MAX_RETRY, 2: re-issues allowed after the first request before the miss is declared failed.
- CLK  in  1  single clock; all state on posedge.
- RESET  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch is presenting a PC this cycle.
- fetch_pc  in  32  PC being read from the cache (the cache's read address).
- cache_hit  in  1  cache read-hit result for fetch_pc.
- flush  in  1  fetch redirect; abandons any miss in progress.
- stall_fetch  out  1  fetch must hold fetch_pc.
- fetch_error  out  1  refill failed after all retries; sticky until flush.
- fill_write_request  out  1  one-cycle cache write strobe.
- fill_write_address  out  32  PC to write (the missed PC).
- fill_write_data  out  32  instruction word to write.
- mem_req  out  1  memory read request, held until granted.
- mem_addr  out  32  word-aligned read address ({miss_pc[31:2],2'b00}).
- mem_req_id  out  1  transaction tag for the current request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response valid.
- mem_rsp_id  in  1  tag of the response.
- mem_rdata  in  32  response data.

## Operation
- States: IDLE, REQ, WAIT, FILL, ERR.
- IDLE: fetch_valid & !cache_hit & !flush → latch miss_pc = fetch_pc, clear retry_cnt, go to REQ.
- REQ: mem_req=1, and mem_addr and mem_req_id are stable. When mem_gnt=1, clear timeout_cnt and go to WAIT.
- WAIT: timeout_cnt increments each cycle.
  - mem_rvalid & mem_rsp_id==cur_id → capture mem_rdata, go to FILL.
  - Otherwise, when timeout_cnt reaches TIMEOUT_CYCLES-1: if retry_cnt<MAX_RETRY, increment retry_cnt, toggle cur_id and return to REQ. If not, go to ERR.
- FILL: fill_write_request=1, fill_write_address=miss_pc, fill_write_data=captured word. Next state is IDLE.
- ERR: fetch_error=1, stall_fetch=1. Leave only on flush.
- cur_id toggles on every new request and on every retry. A response whose tag mismatches, or that arrives outside WAIT, is silently discarded.
- flush has priority in every state. The next state is IDLE, no fill is written, fetch_error clears, and cur_id toggles so any in-flight response is discarded. A request abandoned in REQ is dropped without waiting for mem_gnt. Flush in FILL suppresses the write.
- stall_fetch = (state!=IDLE) | (fetch_valid & !cache_hit). This is combinational, so the miss stalls in its own detection cycle.
- Outputs not listed above for a state are 0.

## Timing
- Reset values: state=IDLE; stall_fetch, fetch_error, fill_write_request and mem_req all 0; address, data and id outputs 0; cur_id=0; counters 0.
- Miss seen at cycle 0 → mem_req high at cycle 1.
- Grant at cycle g; the earliest accepted response is at g+1. The response at cycle r is followed by fill_write_request at r+1.
- The state is IDLE at r+2, and the cache hits on the held PC from r+2.
- The minimum miss penalty, with a same-cycle grant and a next-cycle response, is 4 cycles of stall.
- Timeout: with no response, the request is re-issued at grant+TIMEOUT_CYCLES+1. Total attempts = MAX_RETRY+1, then ERR.
- A response that arrives in the same cycle as the timeout expiry is accepted; the response wins.
- Reset asserted mid-miss returns the block to IDLE immediately, and no fill is issued.

## Structure
- Shared fetch package holds the state encoding typedef, the PC width (32) and the word-align helper constant.
- One natural sub-module: icache_refill_timer, holding the timeout counter and retry counter with expire/exhausted outputs. Everything else stays flat.

## Test plan
- Hit path: fetch_valid=1 and cache_hit=1 for 10 cycles → stall_fetch=0, mem_req=0 and fill_write_request=0 throughout.
- Basic miss: pc=0x0000_1040, grant on first cycle, rvalid with data 0xDEADBEEF one cycle later → mem_addr=0x0000_1040. Then one fill pulse with address 0x0000_1040 and data 0xDEADBEEF. Stall lasts exactly 4 cycles.
- Timeout/retry: TIMEOUT_CYCLES=4, no response to the first request → re-request with toggled mem_req_id. A late response carrying the old id is ignored; the new-id response fills.
- Exhaustion: MAX_RETRY=2, no responses ever → exactly 3 grants, then fetch_error=1 with stall held. Flush clears both the next cycle.
- Flush in WAIT: flush one cycle after grant, then a matching-old-id response → no fill, state IDLE. A subsequent miss proceeds normally.
- Async reset: RESET low during WAIT → all outputs 0 immediately (no clock needed). No fill after RESET is released.
